// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad types, key codes and code-to-letter lookup
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] KEY_SUBMIT_LETTER = 4'd12;  // R3C0
  localparam logic [3:0] KEY_SUBMIT_WORD   = 4'd14;  // R3C2

  // Letters offered by the game FSM; submit keys and spares map to a space.
  localparam logic [7:0] LETTER_NONE = 8'h20;
  localparam logic [7:0] LETTER_BASE = 8'h41;

  function automatic logic [7:0] key_letter(input logic [3:0] code);
    logic [7:0] letter;
    letter = LETTER_NONE;
    if (code < 4'd12)
      letter = LETTER_BASE + {4'd0, code};
    else if (code == 4'd13)
      letter = LETTER_BASE + 8'd12;
    else if (code == 4'd15)
      letter = LETTER_BASE + 8'd13;
    return letter;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] col_index(input logic [3:0] c);
    logic [1:0] idx;
    idx = 2'd0;
    if (c[3])      idx = 2'd3;
    else if (c[2]) idx = 2'd2;
    else if (c[1]) idx = 2'd1;
    return idx;
  endfunction

  // row[3] is R0, so the index counts down from the top bit.
  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd0;
    if (r[0])      idx = 2'd3;
    else if (r[1]) idx = 2'd2;
    else if (r[2]) idx = 2'd1;
    return idx;
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer, asynchronous active-high reset
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad column scanner with press/release debounce
// Optional autorepeat in HELD when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 2000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DLY   = 50000,
  parameter int REPEAT_PER   = 20000
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int MAX_PARAM = max2(max2(SCAN_DIV, DEBOUNCE_CNT), max2(REPEAT_DLY, REPEAT_PER));
`else
  localparam int MAX_PARAM = max2(SCAN_DIV, DEBOUNCE_CNT);
`endif
  localparam int CNT_W = $clog2(MAX_PARAM) + 1;

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEBOUNCE_CNT);
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PER - 1);
`endif

  logic [3:0]       rs;
  scan_state_t      state;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lat_row;
  logic [1:0]       lat_col;
`ifdef KEYPAD_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_first;
`endif

  sync2 #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [3:0] rotl(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_SCAN;
      col       <= 4'b0001;
      div_cnt   <= '0;
      cnt       <= '0;
      lat_row   <= 4'd0;
      lat_col   <= 2'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      key_valid <= 1'b0;
      unique case (state)
        ST_SCAN: begin
          // Sample only on the last dwell cycle so rs has settled through the synchronizer.
          if (div_cnt == SCAN_LAST) begin
            div_cnt <= '0;
            if ($onehot(rs)) begin
              lat_row <= rs;
              lat_col <= col_index(col);
              cnt     <= '0;
              state   <= ST_DEBOUNCE;
            end else begin
              col <= rotl(col);
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        ST_DEBOUNCE: begin
          if (rs != lat_row) begin
            state   <= ST_SCAN;
            cnt     <= '0;
            div_cnt <= '0;
            col     <= rotl(col);
          end else if (cnt == DEB_MAX) begin
            key_code  <= {row_index(lat_row), lat_col};
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            cnt       <= '0;
            state     <= ST_HELD;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        ST_HELD: begin
          if (rs == 4'd0) begin
            cnt   <= '0;
            state <= ST_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rpt_cnt == (rpt_first ? RPT_DLY_LAST : RPT_PER_LAST)) begin
            key_valid <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= sat_inc(rpt_cnt);
          end
`endif
        end

        ST_RELEASE: begin
          // A returning row is contact bounce on release, not a new press.
          if (rs != 4'd0) begin
            cnt   <= '0;
            state <= ST_HELD;
          end else if (cnt == DEB_MAX) begin
            key_held <= 1'b0;
            cnt      <= '0;
            div_cnt  <= '0;
            col      <= rotl(col);
            state    <= ST_SCAN;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - self-checking bench for keypad_scan with a keypad model
module tb_keypad_scan;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RDLY      = 40;
  localparam int RPER      = 16;
  localparam int POST_HOLD = 30;
`else
  localparam int POST_HOLD = 100;
`endif

  logic       tb_clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic       press_active = 1'b0;
  logic [3:0] press_row = 4'd0;
  logic [3:0] press_col = 4'b0001;

  int         n_checks = 0;
  int         n_fail = 0;
  int         strobe_cnt = 0;
  int         ncyc = 0;
  logic [3:0] last_code = 4'd0;
  int         strobe_cyc[$];

  keypad_scan #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEB)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DLY   (RDLY),
    .REPEAT_PER   (RPER)
`endif
  ) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 tb_clk = ~tb_clk;

  // Keypad model: a closed switch only connects its row while its column is driven.
  always_comb row = (press_active && (col == press_col)) ? press_row : 4'b0000;

  always @(posedge tb_clk) begin
    #2;
    ncyc++;
    if (key_valid === 1'b1) begin
      strobe_cnt++;
      last_code = key_code;
      strobe_cyc.push_back(ncyc);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge tb_clk);
  endtask

  task automatic set_key(input int r, input int c);
    press_row = 4'b1000 >> r;
    press_col = 4'b0001 << c;
  endtask

  task automatic release_key(input string nm);
    bit cleared;
    press_active = 1'b0;
    idle(DEB);
    n_checks++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL %s held_during_release: got %b want 1", nm, key_held);
    end
    cleared = 0;
    for (int t = 0; t < 12 && !cleared; t++) begin
      @(negedge tb_clk);
      if (key_held === 1'b0) cleared = 1;
    end
    n_checks++;
    if (!cleared) begin
      n_fail++;
      $display("FAIL %s held_clear: got %b want 0 within %0d cycles", nm, key_held, DEB + 12);
    end
  endtask

  task automatic wait_strobe(input string nm, input int budget);
    bit got;
    got = 0;
    for (int t = 0; t < budget && !got; t++) begin
      @(negedge tb_clk);
      if (strobe_cnt > 0) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s strobe_timeout: got %0d strobes want 1 within %0d cycles", nm, strobe_cnt, budget);
    end
  endtask

  task automatic do_press(input int r, input int c, input string nm);
    logic [3:0] exp_code;
    exp_code = 4'(r * 4 + c);
    @(negedge tb_clk);
    strobe_cnt = 0;
    set_key(r, c);
    press_active = 1'b1;
    wait_strobe(nm, 80);
    idle(POST_HOLD);
    n_checks++;
    if (strobe_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s strobe_count: got %0d want 1", nm, strobe_cnt);
    end
    n_checks++;
    if (last_code !== exp_code) begin
      n_fail++;
      $display("FAIL %s key_code: got %0d want %0d", nm, last_code, exp_code);
    end
    n_checks++;
    if (key_held !== 1'b1) begin
      n_fail++;
      $display("FAIL %s key_held: got %b want 1", nm, key_held);
    end
    n_checks++;
    if (col !== press_col) begin
      n_fail++;
      $display("FAIL %s col_frozen: got %b want %b", nm, col, press_col);
    end
    release_key(nm);
    n_checks++;
    if (strobe_cnt !== 1) begin
      n_fail++;
      $display("FAIL %s strobe_after_release: got %0d want 1", nm, strobe_cnt);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_col;
    rst = 1'b1;
    idle(3);
    n_checks++;
    if (col !== 4'b0001) begin n_fail++; $display("FAIL reset_col: got %b want 0001", col); end
    n_checks++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL reset_key_code: got %0d want 0", key_code); end
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
    n_checks++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_key_held: got %b want 0", key_held); end
    rst = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge tb_clk);
      exp_col = 4'b0001 << ((k / SCAN_DIV) % 4);
      n_checks++;
      if (col !== exp_col) begin
        n_fail++;
        $display("FAIL scan_rotate[%0d]: got %b want %b", k, col, exp_col);
      end
    end
  endtask

  task automatic test_press_r0c1();
    do_press(0, 1, "press_r0c1");
  endtask

  task automatic test_press_r3c0();
    do_press(3, 0, "press_r3c0");
    n_checks++;
    if (last_code !== KEY_SUBMIT_LETTER) begin
      n_fail++;
      $display("FAIL submit_letter_code: got %0d want 12", last_code);
    end
  endtask

  task automatic test_random_keys();
    int r;
    int c;
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(3, 0));
      c = int'($urandom_range(3, 0));
      do_press(r, c, $sformatf("random_r%0dc%0d", r, c));
    end
  endtask

  task automatic test_bounce();
    int r;
    int c;
    r = int'($urandom_range(3, 0));
    c = int'($urandom_range(3, 0));
    @(negedge tb_clk);
    strobe_cnt = 0;
    set_key(r, c);
    for (int i = 0; i < 10; i++) begin
      press_active = (i % 2 == 0);
      idle(3);
    end
    n_checks++;
    if (strobe_cnt !== 0) begin
      n_fail++;
      $display("FAIL bounce_no_strobe: got %0d strobes want 0", strobe_cnt);
    end
    press_active = 1'b1;
    wait_strobe("bounce_settle", 80);
    idle(20);
    n_checks++;
    if (strobe_cnt !== 1) begin
      n_fail++;
      $display("FAIL bounce_one_strobe: got %0d want 1", strobe_cnt);
    end
    n_checks++;
    if (last_code !== 4'(r * 4 + c)) begin
      n_fail++;
      $display("FAIL bounce_code: got %0d want %0d", last_code, r * 4 + c);
    end
    release_key("bounce");
  endtask

  task automatic test_ghost();
    logic [3:0] seen;
    @(negedge tb_clk);
    strobe_cnt = 0;
    press_row = 4'b1010;
    press_col = 4'b0001 << $urandom_range(3, 0);
    press_active = 1'b1;
    seen = 4'd0;
    repeat (60) begin
      @(negedge tb_clk);
      seen = seen | col;
    end
    press_active = 1'b0;
    n_checks++;
    if (strobe_cnt !== 0) begin n_fail++; $display("FAIL ghost_no_strobe: got %0d want 0", strobe_cnt); end
    n_checks++;
    if (seen !== 4'b1111) begin n_fail++; $display("FAIL ghost_rotating: got cols %b want 1111", seen); end
    n_checks++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL ghost_held: got %b want 0", key_held); end
  endtask

  task automatic test_release_glitch();
    int r;
    int c;
    r = int'($urandom_range(3, 0));
    c = int'($urandom_range(3, 0));
    @(negedge tb_clk);
    strobe_cnt = 0;
    set_key(r, c);
    press_active = 1'b1;
    wait_strobe("glitch_press", 80);
    idle(10);
    press_active = 1'b0;
    idle(4);
    press_active = 1'b1;
    idle(2);
    n_checks++;
    if (key_held !== 1'b1) begin n_fail++; $display("FAIL glitch_held: got %b want 1", key_held); end
    release_key("glitch");
    n_checks++;
    if (strobe_cnt !== 1) begin n_fail++; $display("FAIL glitch_strobes: got %0d want 1", strobe_cnt); end
  endtask

  task automatic test_reset_mid_debounce();
    int  c;
    bit  ok;
    c = int'($urandom_range(3, 0));
    @(negedge tb_clk);
    strobe_cnt = 0;
    set_key(int'($urandom_range(3, 0)), c);
    press_active = 1'b1;
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      if (col !== press_col) ok = 1; else @(negedge tb_clk);
    end
    ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge tb_clk);
      if (col === press_col) ok = 1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rstdeb_reach_col: got %b want %b", col, press_col); end
    idle(6);
    rst = 1'b1;
    @(posedge tb_clk);
    #1;
    n_checks++;
    if (col !== 4'b0001) begin n_fail++; $display("FAIL rstdeb_col: got %b want 0001", col); end
    n_checks++;
    if (key_valid !== 1'b0) begin n_fail++; $display("FAIL rstdeb_valid: got %b want 0", key_valid); end
    n_checks++;
    if (key_held !== 1'b0) begin n_fail++; $display("FAIL rstdeb_held: got %b want 0", key_held); end
    n_checks++;
    if (key_code !== 4'd0) begin n_fail++; $display("FAIL rstdeb_code: got %0d want 0", key_code); end
    @(negedge tb_clk);
    press_active = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(40);
    n_checks++;
    if (strobe_cnt !== 0) begin n_fail++; $display("FAIL rstdeb_no_strobe: got %0d want 0", strobe_cnt); end
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  task automatic test_autorepeat();
    int exp_off;
    @(negedge tb_clk);
    strobe_cnt = 0;
    strobe_cyc.delete();
    set_key(int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
    press_active = 1'b1;
    wait_strobe("autorepeat", 80);
    idle(95);
    release_key("autorepeat");
    n_checks++;
    if (strobe_cyc.size() !== 5) begin
      n_fail++;
      $display("FAIL autorepeat_count: got %0d want 5", strobe_cyc.size());
    end
    for (int j = 1; j < 5 && j < strobe_cyc.size(); j++) begin
      exp_off = RDLY + (j - 1) * RPER;
      n_checks++;
      if (strobe_cyc[j] - strobe_cyc[0] !== exp_off) begin
        n_fail++;
        $display("FAIL autorepeat_offset[%0d]: got %0d want %0d", j, strobe_cyc[j] - strobe_cyc[0], exp_off);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_press_r0c1();
    test_press_r3c0();
    test_random_keys();
    test_bounce();
    test_ghost();
    test_release_glitch();
    test_reset_mid_debounce();
`ifdef KEYPAD_AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
